// File: rtl/sba_bus_arbiter.sv
// Two-master arbiter (core LSU = m0, debug SBA = m1) in front of one downstream port.
// One transaction outstanding at a time, with a lock while waiting for grant and a response timeout.
module sba_bus_arbiter #(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        s_req_o,
  input  logic        s_gnt_i,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_err_i
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        lock_q, lock_d;
  logic        lock_sel_q, lock_sel_d;
  logic [15:0] cnt_q, cnt_d;

  logic        any_req;
  logic        lock_hold;
  logic        winner;
  logic        timeout;
  logic        rsp_fire;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // A locked requester keeps the port only while it still holds its request.
  always_comb begin
    any_req   = m0_req_i | m1_req_i;
    lock_hold = lock_q & (lock_sel_q ? m1_req_i : m0_req_i);
    if (lock_hold) begin
      winner = lock_sel_q;
    end else if (m0_req_i && m1_req_i) begin
      winner = (PRIO_MODE == 0) ? 1'b1 : ~last_q;
    end else begin
      winner = m1_req_i;
    end
  end

  assign timeout  = (cnt_q == TimeoutLast);
  assign rsp_fire = (state_q == StBusy) & (s_rvalid_i | timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          if (s_gnt_i) begin
            state_d = StBusy;
            owner_d = winner;
            last_d  = winner;
            lock_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            lock_d     = 1'b1;
            lock_sel_d = winner;
          end
        end else begin
          lock_d = 1'b0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 16'd1;
        // A real response in the timeout cycle takes precedence over the forced error.
        if (s_rvalid_i || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_req_o   = (state_q == StIdle) & any_req;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_we_o    = winner ? m1_we_i    : m0_we_i;
      s_be_o    = winner ? m1_be_i    : m0_be_i;
      s_addr_o  = winner ? m1_addr_i  : m0_addr_i;
      s_wdata_o = winner ? m1_wdata_i : m0_wdata_i;
    end
    m0_gnt_o = s_gnt_i & s_req_o & ~winner;
    m1_gnt_o = s_gnt_i & s_req_o & winner;

    rsp_rdata = s_rvalid_i ? s_rdata_i : 32'd0;
    rsp_err   = s_rvalid_i ? s_err_i : 1'b1;

    m0_rvalid_o = rsp_fire & ~owner_q;
    m0_rdata_o  = m0_rvalid_o ? rsp_rdata : 32'd0;
    m0_err_o    = m0_rvalid_o & rsp_err;
    m1_rvalid_o = rsp_fire & owner_q;
    m1_rdata_o  = m1_rvalid_o ? rsp_rdata : 32'd0;
    m1_err_o    = m1_rvalid_o & rsp_err;
  end

endmodule

// File: doc/sba_bus_arbiter.md
SBA_BUS_ARBITER -- requirements
Module: sba_bus_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0; 0 = fixed priority (m1 debug wins), 1 = round-robin.
REQ-002 Parameter TIMEOUT, default 255; cycles to wait for a response before a forced error return; legal range 2..65535.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 The following requester signals SHALL exist for N in {0 = core LSU, 1 = debug SBA master}:
REQ-006 mN_req_i  in  1  request; held with payload until granted.
REQ-007 mN_gnt_o  out  1  grant; request accepted this cycle.
REQ-008 mN_we_i  in  1  write enable.
REQ-009 mN_be_i  in  4  byte enables.
REQ-010 mN_addr_i / mN_wdata_i  in  32 each  address, write data.
REQ-011 mN_rvalid_o  out  1  response valid, one cycle.
REQ-012 mN_rdata_o  out  32  read data; 0 when mN_rvalid_o is 0.
REQ-013 mN_err_o  out  1  bus error; qualified by mN_rvalid_o.
REQ-014 s_req_o / s_gnt_i  out / in  1 each  downstream request and grant.
REQ-015 s_we_o, s_be_o, s_addr_o, s_wdata_o  out  1/4/32/32  downstream payload.
REQ-016 s_rvalid_i, s_rdata_i, s_err_i  in  1/32/1  downstream response.

Function
REQ-017 The FSM SHALL have two states: IDLE and BUSY; only one downstream transaction SHALL be outstanding.
REQ-018 IDLE, no lock: s_req_o = m0_req_i | m1_req_i; winner = the sole requester, or on conflict m1 (PRIO_MODE=0), or the requester that is not last_owner (PRIO_MODE=1).
REQ-019 When s_req_o=1 and s_gnt_i=0, the winner SHALL be locked; s_req_o and the payload SHALL stay sourced from the locked requester until granted, regardless of other requests.
REQ-020 s_we_o/s_be_o/s_addr_o/s_wdata_o SHALL be combinationally muxed from the winner; all 0 when no request.
REQ-021 mN_gnt_o = s_gnt_i & s_req_o & (winner == N); the non-winner gnt SHALL be 0.
REQ-022 On grant: state -> BUSY; owner and last_owner <= winner; lock cleared; timeout counter <= 0.
REQ-023 BUSY: s_req_o=0; both gnt=0; new requests wait; counter increments by 1 per cycle.
REQ-024 BUSY with s_rvalid_i=1: owner's rvalid/rdata/err = s_rvalid_i/s_rdata_i/s_err_i in the same cycle (zero latency); state -> IDLE.
REQ-025 BUSY, counter == TIMEOUT-1, s_rvalid_i=0: owner rvalid=1, err=1, rdata=0; state -> IDLE.
REQ-026 If s_rvalid_i arrives in the same cycle as the timeout, the real response SHALL win (REQ-024).
REQ-027 s_rvalid_i in IDLE (late response after timeout, spurious) SHALL be dropped; no mN_rvalid_o.
REQ-028 The non-owner's rvalid, rdata and err SHALL always be 0.
REQ-029 A request SHALL NOT be granted in the cycle its predecessor's response returns; earliest grant is the next cycle (one-cycle bubble).
REQ-030 A requester dropping mN_req_i while locked SHALL release the lock; arbitration re-evaluates in the same cycle.

Reset
REQ-031 Reset SHALL set state=IDLE, owner=0, last_owner=0, lock=0 and counter=0; all gnt/rvalid/err outputs 0; s_req_o follows inputs per REQ-018.
REQ-032 Reset during BUSY SHALL abandon the outstanding transaction; no response is returned to any requester afterwards.

Verification
REQ-033 m0 read addr 0x1000 alone, s_gnt_i same cycle, s_rvalid_i 3 cycles later with rdata 0xDEADBEEF -> m0_gnt_o=1 one cycle; m0_rvalid_o=1 with 0xDEADBEEF; m1 outputs stay 0.
REQ-034 PRIO_MODE=0: m0 and m1 request together, three back-to-back rounds -> m1 granted every round, m0 only after m1 drops its request.
REQ-035 PRIO_MODE=1: both request continuously after reset -> grant order m1, m0, m1, m0; one idle cycle between each response and the next grant.
REQ-036 m0 requests; s_gnt_i held 0 for 4 cycles; m1 raises its request in cycle 2 -> s_addr_o stays at m0's address; m0 granted first (lock).
REQ-037 TIMEOUT=4: m1 write granted, no s_rvalid_i -> m1_rvalid_o=1, m1_err_o=1, rdata 0 on BUSY cycle 4; a later s_rvalid_i is dropped.
REQ-038 rst_n asserted in BUSY, then s_rvalid_i pulses after release -> no mN_rvalid_o; the next request is arbitrated normally.
